// File: rtl/gb80_fetch_decoder.sv
// gb80_fetch_decoder
//   Multi-byte instruction fetch/decode unit for the GB80 core. Bytes arrive
//   over a valid/ready handshake. The unit collects an optional 0xCB prefix,
//   the opcode byte and up to two little-endian immediate bytes. It then holds
//   one decoded instruction until the sequencer acknowledges it.
//
// Ports
//   i_clk            system clock, rising edge
//   i_reset          synchronous active-low reset
//   i_data_in        instruction byte from the bus
//   i_data_valid     i_data_in holds a byte
//   o_data_ready     a byte is accepted this cycle (low only while holding)
//   o_valid          decoded instruction available
//   i_ack            sequencer consumes the instruction
//   o_opcode_type    0 = base table, 1 = CB-prefixed table
//   o_opcode         opcode byte (the byte after the prefix when prefixed)
//   o_lit_len        number of immediate bytes (0..2)
//   o_literal_value  assembled immediate, little-endian
//   o_addr_A         opcode[5:3], zero-extended
//   o_addr_B         opcode[2:0], zero-extended
module gb80_fetch_decoder #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 3,
  parameter logic [DATA_WIDTH-1:0] PREFIX_CODE = 8'hCB
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [DATA_WIDTH-1:0]     i_data_in,
  input  logic                      i_data_valid,
  output logic                      o_data_ready,
  output logic                      o_valid,
  input  logic                      i_ack,
  output logic                      o_opcode_type,
  output logic [DATA_WIDTH-1:0]     o_opcode,
  output logic [1:0]                o_lit_len,
  output logic [2*DATA_WIDTH-1:0]   o_literal_value,
  output logic [ADDR_WIDTH-1:0]     o_addr_A,
  output logic [ADDR_WIDTH-1:0]     o_addr_B
);

  localparam logic [2:0] S_OPCODE = 3'd0;
  localparam logic [2:0] S_CB     = 3'd1;
  localparam logic [2:0] S_LIT_LO = 3'd2;
  localparam logic [2:0] S_LIT_HI = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  logic [2:0]              r_state;
  logic                    r_valid;
  logic                    r_type;
  logic [DATA_WIDTH-1:0]   r_opcode;
  logic [1:0]              r_lit_len;
  logic [2*DATA_WIDTH-1:0] r_literal;
  logic [ADDR_WIDTH-1:0]   r_addr_a;
  logic [ADDR_WIDTH-1:0]   r_addr_b;

  logic                    w_ready;
  logic                    w_xfer;
  logic [1:0]              w_len;

  // Immediate-byte count for a base-table opcode.
  function automatic logic [1:0] f_lit_len(input logic [7:0] op);
    logic [1:0] len;
    case (op)
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hC4, 8'hCA,
      8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:
        len = 2'd2;
      8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE, 8'hD6, 8'hDE,
      8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hE0, 8'hF0, 8'hE8, 8'hF8:
        len = 2'd1;
      default:
        // LD r,d8 family: 00xx_x110
        len = (op[7:6] == 2'b00 && op[2:0] == 3'b110) ? 2'd1 : 2'd0;
    endcase
    return len;
  endfunction

  // Ready depends on state alone, so it never loops back through i_data_valid.
  assign w_ready = (r_state != S_HOLD);
  assign w_xfer  = i_data_valid && w_ready;
  assign w_len   = f_lit_len(i_data_in[7:0]);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= S_OPCODE;
      r_valid   <= 1'b0;
      r_type    <= 1'b0;
      r_opcode  <= '0;
      r_lit_len <= 2'd0;
      r_literal <= '0;
      r_addr_a  <= '0;
      r_addr_b  <= '0;
    end else begin
      case (r_state)
        S_OPCODE: begin
          if (w_xfer) begin
            if (i_data_in == PREFIX_CODE) begin
              r_state <= S_CB;
            end else begin
              r_opcode  <= i_data_in;
              r_type    <= 1'b0;
              r_lit_len <= w_len;
              r_addr_a  <= ADDR_WIDTH'(i_data_in[5:3]);
              r_addr_b  <= ADDR_WIDTH'(i_data_in[2:0]);
              if (w_len == 2'd0) begin
                r_state <= S_HOLD;
                r_valid <= 1'b1;
              end else begin
                r_state <= S_LIT_LO;
              end
            end
          end
        end
        S_CB: begin
          // Any byte here, including another PREFIX_CODE, is the CB-table opcode.
          if (w_xfer) begin
            r_opcode  <= i_data_in;
            r_type    <= 1'b1;
            r_lit_len <= 2'd0;
            r_addr_a  <= ADDR_WIDTH'(i_data_in[5:3]);
            r_addr_b  <= ADDR_WIDTH'(i_data_in[2:0]);
            r_state   <= S_HOLD;
            r_valid   <= 1'b1;
          end
        end
        S_LIT_LO: begin
          if (w_xfer) begin
            r_literal <= {{DATA_WIDTH{1'b0}}, i_data_in};
            if (r_lit_len == 2'd1) begin
              r_state <= S_HOLD;
              r_valid <= 1'b1;
            end else begin
              r_state <= S_LIT_HI;
            end
          end
        end
        S_LIT_HI: begin
          if (w_xfer) begin
            r_literal[2*DATA_WIDTH-1:DATA_WIDTH] <= i_data_in;
            r_state <= S_HOLD;
            r_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (i_ack) begin
            r_state <= S_OPCODE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_OPCODE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_data_ready    = w_ready;
  assign o_valid         = r_valid;
  assign o_opcode_type   = r_type;
  assign o_opcode        = r_opcode;
  assign o_lit_len       = r_lit_len;
  assign o_literal_value = r_literal;
  assign o_addr_A        = r_addr_a;
  assign o_addr_B        = r_addr_b;

endmodule

// File: doc/gb80_fetch_decoder.md
Name: gb80_fetch_decoder

Overview:
Multi-byte instruction fetch/decode unit for the GB80 core. It replaces the single-byte decoder. It collects the opcode byte, the optional 0xCB prefix, and 0-2 immediate bytes from the bus through a valid/ready handshake. It then presents one decoded instruction (type, opcode, literal, register fields) to the sequencer and holds it until acknowledged.

Parameters:
DATA_WIDTH, 8, bus byte width; the decode tables are defined for 8 only.
ADDR_WIDTH, 3, register-file address width; must be >= 3; fields are zero-extended.
PREFIX_CODE, 8'hCB, prefix byte that selects the extended opcode table.

Ports:
i_clk  input  1  system clock; all logic on rising edge.
i_reset  input  1  synchronous, active-low reset.
i_data_in  input  DATA_WIDTH  instruction byte from the bus.
i_data_valid  input  1  i_data_in holds a byte.
o_data_ready  output  1  decoder accepts a byte this cycle.
o_valid  output  1  decoded instruction is available.
i_ack  input  1  sequencer consumes the instruction.
o_opcode_type  output  1  0 = base table, 1 = CB-prefixed table.
o_opcode  output  DATA_WIDTH  opcode byte (the byte after the prefix, if prefixed).
o_lit_len  output  2  number of literal bytes: 0, 1 or 2.
o_literal_value  output  2*DATA_WIDTH  immediate value, little-endian assembled.
o_addr_A  output  ADDR_WIDTH  {0, opcode[5:3]}.
o_addr_B  output  ADDR_WIDTH  {0, opcode[2:0]}.

Behaviour:
- Byte transfer occurs when i_data_valid && o_data_ready on a rising edge.
- o_data_ready is driven purely by state: 1 in every state except HOLD.
- States and transitions:
  - OPCODE: on transfer, if byte == PREFIX_CODE go to CB. Otherwise latch opcode, type=0, compute literal length L. L=0 -> HOLD; L>=1 -> LIT_LO.
  - CB: on transfer, latch opcode, type=1, L=0, go to HOLD. A second 0xCB here is the CB-table opcode 0xCB, not a new prefix.
  - LIT_LO: on transfer, latch literal[7:0] and clear literal[15:8]. L=1 -> HOLD; L=2 -> LIT_HI.
  - LIT_HI: on transfer, latch literal[15:8], go to HOLD.
  - HOLD: o_valid=1. On i_ack go to OPCODE; the ack cycle accepts no byte.
- Without a transfer, every fetch state holds. Gaps in i_data_valid of any length are legal.
- Literal length table (base table only):
  - L=2: 01,11,21,31,08,C2,C3,C4,CA,CC,CD,D2,D4,DA,DC,EA,FA.
  - L=1: any opcode with [7:6]=00 and [2:0]=110; also 18,20,28,30,38,C6,CE,D6,DE,E6,EE,F6,FE,E0,F0,E8,F8.
  - L=0: all other opcodes.
- Latency: o_valid rises on the cycle after the final byte transfer. NOP gives 1 cycle of latency; a 3-byte instruction gives 3 transfers + 1.
- All outputs are registered. In HOLD they are stable until the ack edge; i_ack outside HOLD is ignored.
- o_valid deasserts on the cycle after the ack edge. Decoded fields may keep their stale values while o_valid=0.
- Reset (i_reset=0 at an edge):
  - state = OPCODE.
  - o_valid, o_opcode_type, o_opcode, o_lit_len, o_literal_value, o_addr_A, o_addr_B all = 0.
  - o_data_ready = 1 after reset.
  - A partial instruction in progress is discarded, in any state.
  - Reset overrides a simultaneous transfer or ack.

Test Plan:
- Reset, then send 00 -> one cycle later: o_valid=1, type=0, opcode=00, lit_len=0, A=0, B=0. i_ack -> o_valid=0 next cycle.
- Send 01,34,12 with 2-cycle gaps between bytes -> o_valid=1, opcode=01, lit_len=2, literal=0x1234, A=0, B=1.
- Send CB,7C -> type=1, opcode=7C, lit_len=0, A=7, B=4. Send CB,CB -> type=1, opcode=CB.
- Send 06,5A -> lit_len=1, literal=0x005A. Send 3E,FF -> literal=0x00FF, A=7, B=6.
- Decode 00, hold i_ack=0 for 5 cycles while offering byte 21 -> o_data_ready=0, outputs unchanged, 21 not consumed. Ack, then 21,CD,AB -> literal=0xABCD.
- Send 01,34, assert reset for 1 cycle, then send 00 -> no o_valid from the partial instruction; next decode is NOP with lit_len=0.
